// File: rtl/fir_cfg_pkg.sv
// Shared constants and types for the FIR configuration controller:
// register addresses, control-word layout and reset values, FSM states.
package fir_cfg_pkg;

  localparam logic [11:0] ADDR_CMD  = 12'hffd;
  localparam logic [11:0] ADDR_ID   = 12'hffe;
  localparam logic [11:0] ADDR_CTRL = 12'hfff;

  localparam logic        CTRL_RST_BYPASS = 1'b1;
  localparam logic [3:0]  CTRL_RST_SHIFT  = 4'd12;
  localparam logic [11:0] CTRL_RST_TAP    = 12'd0;
  localparam logic [11:0] CTRL_RST_DS     = 12'd1;

  // Field order mirrors bits [28:0] of the CTRL register.
  typedef struct packed {
    logic        bypass;
    logic [3:0]  shift;
    logic [11:0] tap;
    logic [11:0] ds;
  } ctrl_t;

  localparam ctrl_t CTRL_RST = '{
    bypass: CTRL_RST_BYPASS,
    shift:  CTRL_RST_SHIFT,
    tap:    CTRL_RST_TAP,
    ds:     CTRL_RST_DS
  };

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RDWAIT,
    ST_HOLD,
    ST_APPLY,
    ST_CLEAR
  } state_t;

  function automatic logic [31:0] ctrl_to_word(input ctrl_t c);
    return {3'b000, c};
  endfunction

endpackage

// File: rtl/fir_cfg_ctrl.sv
// Register-bus controller for the FIR array: owns the control word, applies it
// after a pipeline drain, forwards coefficient accesses and clears the coefficient RAM.
module fir_cfg_ctrl
  import fir_cfg_pkg::*;
#(
  parameter int CHANNEL      = 8,
  parameter int FIR_LANE     = 4,
  parameter int acw          = 31,
  parameter int pcmaw        = 9,
  parameter int mul_num      = 2,
  parameter int DRAIN_CYCLES = 64
) (
  input  logic                 clk_2,
  input  logic                 rst,
  input  logic [11:0]          reg_addr,
  input  logic                 reg_rd,
  input  logic                 reg_wr,
  input  logic [31:0]          reg_writedata,
  output logic                 reg_ready,
  output logic [31:0]          reg_readdata,
  output logic [pcmaw-2:0]     param_addr,
  output logic                 param_wr,
  output logic                 param_rd,
  output logic [31:0]          param_wrdata,
  input  logic [31:0]          param_readdata,
  output logic                 bypass,
  output logic [3:0]           pcm_out_shift,
  output logic [11:0]          tap_len,
  output logic [11:0]          down_sample,
  output logic                 fir_hold
);

  localparam int CW      = pcmaw - 1;
  localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 1);
  localparam int CNT_W   = (CW > DRAIN_W) ? CW : DRAIN_W;

  localparam logic [CNT_W-1:0] CLEAR_LAST = CNT_W'((1 << CW) - 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYCLES - 1);

  localparam logic [31:0] ID_WORD = {8'h00, 5'(FIR_LANE), 1'(mul_num >> 1), 6'(acw),
                                     4'b0000, 4'(pcmaw), 4'(CHANNEL)};

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  ctrl_t             shadow_q, shadow_d;
  ctrl_t             live_q, live_d;
  logic              pending_q, pending_d;
  logic              fir_hold_q, fir_hold_d;
  logic              reg_ready_q, reg_ready_d;
  logic [31:0]       reg_readdata_q, reg_readdata_d;

  logic              req;
  logic              is_coef;
  logic              is_reg;
  logic              reg_read;
  logic              busy;
  logic [31:0]       reg_rd_val;

  // A request still held during its own ready cycle must not be taken twice.
  assign req      = (reg_rd | reg_wr) & ~reg_ready_q;
  assign is_coef  = (reg_addr[11:CW] == '0);
  assign is_reg   = (reg_addr == ADDR_CMD) || (reg_addr == ADDR_ID) || (reg_addr == ADDR_CTRL);
  assign reg_read = req & ~reg_wr & is_reg;
  assign busy     = (state_q != ST_IDLE);

  always_comb begin
    reg_rd_val = 32'h0;
    case (reg_addr)
      ADDR_CMD:  reg_rd_val = {30'b0, pending_q, busy};
      ADDR_ID:   reg_rd_val = ID_WORD;
      ADDR_CTRL: reg_rd_val = ctrl_to_word(shadow_q);
      default:   reg_rd_val = 32'h0;
    endcase
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    shadow_d       = shadow_q;
    live_d         = live_q;
    pending_d      = pending_q;
    fir_hold_d     = fir_hold_q;
    reg_ready_d    = 1'b0;
    reg_readdata_d = 32'h0;
    param_addr     = reg_addr[CW-1:0];
    param_wrdata   = reg_writedata;
    param_wr       = 1'b0;
    param_rd       = 1'b0;

    // Status/ID/CTRL reads bypass the FSM so software can poll while busy.
    if (reg_read) begin
      reg_ready_d    = 1'b1;
      reg_readdata_d = reg_rd_val;
    end

    case (state_q)
      ST_IDLE: begin
        if (req && !reg_read) begin
          if (is_coef) begin
            if (reg_wr) begin
              param_wr    = 1'b1;
              reg_ready_d = 1'b1;
            end else begin
              // Strobe in the request cycle so the registered RAM data lands in RDWAIT.
              param_rd = 1'b1;
              state_d  = ST_RDWAIT;
            end
          end else if (reg_wr && reg_addr == ADDR_CTRL) begin
            shadow_d    = ctrl_t'(reg_writedata[28:0]);
            pending_d   = 1'b1;
            fir_hold_d  = 1'b1;
            cnt_d       = '0;
            reg_ready_d = 1'b1;
            state_d     = ST_HOLD;
          end else if (reg_wr && reg_addr == ADDR_CMD && reg_writedata[0]) begin
            fir_hold_d  = 1'b1;
            cnt_d       = '0;
            reg_ready_d = 1'b1;
            state_d     = ST_CLEAR;
          end else begin
            reg_ready_d = 1'b1;
          end
        end
      end
      ST_RDWAIT: begin
        reg_ready_d    = 1'b1;
        reg_readdata_d = param_readdata;
        state_d        = ST_IDLE;
      end
      ST_HOLD: begin
        if (cnt_q == DRAIN_LAST) begin
          state_d = ST_APPLY;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_APPLY: begin
        live_d     = shadow_q;
        pending_d  = 1'b0;
        fir_hold_d = 1'b0;
        state_d    = ST_IDLE;
      end
      ST_CLEAR: begin
        param_wr     = 1'b1;
        param_addr   = cnt_q[CW-1:0];
        param_wrdata = 32'h0;
        if (cnt_q == CLEAR_LAST) begin
          cnt_d      = '0;
          fir_hold_d = 1'b0;
          state_d    = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_2 or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      shadow_q       <= CTRL_RST;
      live_q         <= CTRL_RST;
      pending_q      <= 1'b0;
      fir_hold_q     <= 1'b0;
      reg_ready_q    <= 1'b0;
      reg_readdata_q <= 32'h0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      shadow_q       <= shadow_d;
      live_q         <= live_d;
      pending_q      <= pending_d;
      fir_hold_q     <= fir_hold_d;
      reg_ready_q    <= reg_ready_d;
      reg_readdata_q <= reg_readdata_d;
    end
  end

  assign reg_ready     = reg_ready_q;
  assign reg_readdata  = reg_readdata_q;
  assign fir_hold      = fir_hold_q;
  assign bypass        = live_q.bypass;
  assign pcm_out_shift = live_q.shift;
  assign tap_len       = live_q.tap;
  assign down_sample   = live_q.ds;

endmodule

// File: tb/tb_fir_cfg_ctrl.sv
// Directed bench for fir_cfg_ctrl: a coefficient RAM model plus scoreboards
// for read data and coefficient writes, with timing checks on hold/clear windows.
module tb_fir_cfg_ctrl;

  localparam int DRAIN = 64;
  localparam int NCOEF = 256;
  localparam logic [31:0] ID_EXP   = 32'h0025F098;
  localparam logic [31:0] CTRL_RST = 32'h1C000001;

  logic        clk_2 = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] reg_addr = '0;
  logic        reg_rd = 1'b0;
  logic        reg_wr = 1'b0;
  logic [31:0] reg_writedata = '0;
  logic        reg_ready;
  logic [31:0] reg_readdata;
  logic [7:0]  param_addr;
  logic        param_wr;
  logic        param_rd;
  logic [31:0] param_wrdata;
  logic [31:0] param_readdata;
  logic        bypass;
  logic [3:0]  pcm_out_shift;
  logic [11:0] tap_len;
  logic [11:0] down_sample;
  logic        fir_hold;

  always #5 clk_2 = ~clk_2;

  fir_cfg_ctrl #(
    .CHANNEL(8), .FIR_LANE(4), .acw(31), .pcmaw(9), .mul_num(2), .DRAIN_CYCLES(DRAIN)
  ) dut (
    .clk_2(clk_2), .rst(rst),
    .reg_addr(reg_addr), .reg_rd(reg_rd), .reg_wr(reg_wr), .reg_writedata(reg_writedata),
    .reg_ready(reg_ready), .reg_readdata(reg_readdata),
    .param_addr(param_addr), .param_wr(param_wr), .param_rd(param_rd),
    .param_wrdata(param_wrdata), .param_readdata(param_readdata),
    .bypass(bypass), .pcm_out_shift(pcm_out_shift), .tap_len(tap_len),
    .down_sample(down_sample), .fir_hold(fir_hold)
  );

  // Coefficient RAM with one-cycle registered read, preloaded with non-zero data.
  logic [31:0] mem [0:NCOEF-1];
  initial begin
    for (int i = 0; i < NCOEF; i++) mem[i] = 32'hDEAD0000 | i;
    param_readdata = 32'h0;
  end
  always @(posedge clk_2) begin
    if (param_wr) mem[param_addr] <= param_wrdata;
    if (param_rd) param_readdata <= mem[param_addr];
  end

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk_2) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    bit          chk;
    logic [31:0] data;
  } rd_exp_t;
  typedef struct {
    bit          clr;
    logic [7:0]  addr;
    logic [31:0] data;
  } wr_exp_t;

  rd_exp_t rd_q[$];
  wr_exp_t wr_q[$];
  rd_exp_t re;
  wr_exp_t we;
  int last_wr_cyc = -1;
  int first_clr_cyc = -1;
  int last_clr_cyc = -1;
  int clr_gap_bad = 0;

  always @(negedge clk_2) begin
    if (!rst && reg_ready) begin
      check("ready_expected", 64'(rd_q.size() != 0), 64'd1);
      if (rd_q.size() != 0) begin
        re = rd_q.pop_front();
        if (re.chk) check("readdata", 64'(reg_readdata), 64'(re.data));
      end
    end
    if (!rst && param_wr) begin
      check("param_wr_expected", 64'(wr_q.size() != 0), 64'd1);
      if (wr_q.size() != 0) begin
        we = wr_q.pop_front();
        check("param_wr_addr_data", {24'b0, param_addr, param_wrdata}, {24'b0, we.addr, we.data});
        last_wr_cyc = cyc;
        if (we.clr) begin
          if (we.addr == 8'd0) first_clr_cyc = cyc;
          else if (cyc != last_clr_cyc + 1) clr_gap_bad++;
          last_clr_cyc = cyc;
        end
      end
    end
  end

  // Edge tracker for fir_hold and the live control outputs.
  logic        hold_prev = 1'b0;
  logic [28:0] live_prev = '0;
  logic [28:0] live_now;
  int hold_rise_cyc = -1;
  int hold_fall_cyc = -1;
  int live_chg_cyc = -1;
  assign live_now = {bypass, pcm_out_shift, tap_len, down_sample};
  always @(negedge clk_2) begin
    if (fir_hold && !hold_prev) hold_rise_cyc = cyc;
    if (!fir_hold && hold_prev) hold_fall_cyc = cyc;
    if (live_now != live_prev) live_chg_cyc = cyc;
    hold_prev = fir_hold;
    live_prev = live_now;
  end

  task automatic req(input logic rd, input logic wr, input logic [11:0] addr,
                     input logic [31:0] wdata, input int exp_lat,
                     output int start_cyc, output int rdy_cyc);
    bit got;
    int lat;
    @(posedge clk_2); #1;
    reg_rd = rd; reg_wr = wr; reg_addr = addr; reg_writedata = wdata;
    start_cyc = cyc;
    got = 1'b0;
    lat = 0;
    for (int k = 0; k < 400 && !got; k++) begin
      @(negedge clk_2);
      if (reg_ready) begin
        got = 1'b1;
        lat = k;
      end
    end
    rdy_cyc = start_cyc + lat;
    check($sformatf("ready_seen_%03h", addr), 64'(got), 64'd1);
    if (exp_lat >= 0 && got) check($sformatf("latency_%03h", addr), 64'(lat), 64'(exp_lat));
    $display("txn rd=%0d wr=%0d addr=%03h wdata=%08h latency=%0d", rd, wr, addr, wdata, lat);
    @(posedge clk_2); #1;
    reg_rd = 1'b0; reg_wr = 1'b0;
  endtask

  task automatic rd_reg(input logic [11:0] addr, input logic [31:0] exp, input int exp_lat);
    int s, r;
    rd_q.push_back('{chk: 1'b1, data: exp});
    req(1'b1, 1'b0, addr, 32'h0, exp_lat, s, r);
  endtask

  task automatic wr_reg(input logic [11:0] addr, input logic [31:0] data, input int exp_lat,
                        output int s, output int r);
    rd_q.push_back('{chk: 1'b0, data: 32'h0});
    req(1'b0, 1'b1, addr, data, exp_lat, s, r);
  endtask

  task automatic check_live_reset(input string tag);
    check({tag, "_bypass"}, 64'(bypass), 64'd1);
    check({tag, "_shift"}, 64'(pcm_out_shift), 64'd12);
    check({tag, "_tap"}, 64'(tap_len), 64'd0);
    check({tag, "_ds"}, 64'(down_sample), 64'd1);
    check({tag, "_hold"}, 64'(fir_hold), 64'd0);
    check({tag, "_ready"}, 64'(reg_ready), 64'd0);
    check({tag, "_param_wr"}, 64'(param_wr), 64'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s, r, s0, s1;
    bit seen;

    repeat (3) @(posedge clk_2);
    #1;
    check_live_reset("reset");
    @(posedge clk_2); #1;
    rst = 1'b0;

    rd_reg(12'hffe, ID_EXP, 1);
    rd_reg(12'hfff, CTRL_RST, 1);
    rd_reg(12'hffd, 32'h0, 1);

    // Coefficient write then readback.
    wr_q.push_back('{clr: 1'b0, addr: 8'h05, data: 32'h12345678});
    wr_reg(12'h005, 32'h12345678, 1, s, r);
    check("coef_wr_cycle", 64'(last_wr_cyc), 64'(s));
    rd_reg(12'h005, 32'h12345678, 2);

    // rd and wr together behave as a write.
    wr_q.push_back('{clr: 1'b0, addr: 8'h07, data: 32'h0BADCAFE});
    rd_q.push_back('{chk: 1'b0, data: 32'h0});
    req(1'b1, 1'b1, 12'h007, 32'h0BADCAFE, 1, s, r);
    rd_reg(12'h007, 32'h0BADCAFE, 2);

    // Unmapped and no-op register accesses.
    wr_reg(12'h500, 32'hFFFFFFFF, 1, s, r);
    rd_reg(12'h400, 32'h0, 1);
    wr_reg(12'hffd, 32'h0, 1, s, r);
    rd_reg(12'hffd, 32'h0, 1);

    // CTRL write: drain, status during hold, stalled coefficient write.
    wr_reg(12'hfff, 32'h08040004, 1, s0, r);
    rd_reg(12'hffd, 32'h3, 1);
    rd_reg(12'hfff, 32'h08040004, 1);
    wr_q.push_back('{clr: 1'b0, addr: 8'h20, data: 32'hA5A5A5A5});
    wr_reg(12'h020, 32'hA5A5A5A5, -1, s, r);
    check("stalled_ready_cycle", 64'(r), 64'(s0 + DRAIN + 3));
    check("stalled_wr_cycle", 64'(last_wr_cyc), 64'(s0 + DRAIN + 2));
    check("hold_rise", 64'(hold_rise_cyc), 64'(s0 + 1));
    check("hold_fall", 64'(hold_fall_cyc), 64'(s0 + DRAIN + 2));
    check("live_change", 64'(live_chg_cyc), 64'(s0 + DRAIN + 2));
    check("live_bypass", 64'(bypass), 64'd0);
    check("live_shift", 64'(pcm_out_shift), 64'd8);
    check("live_tap", 64'(tap_len), 64'd64);
    check("live_ds", 64'(down_sample), 64'd4);
    rd_reg(12'hffd, 32'h0, 1);

    // Coefficient clear.
    for (int i = 0; i < NCOEF; i++) wr_q.push_back('{clr: 1'b1, addr: 8'(i), data: 32'h0});
    wr_reg(12'hffd, 32'h1, 1, s1, r);
    rd_reg(12'hffd, 32'h1, 1);
    seen = 1'b0;
    for (int k = 0; k < 600 && !seen; k++) begin
      @(negedge clk_2);
      if (!fir_hold) seen = 1'b1;
    end
    @(negedge clk_2);
    check("clear_done_seen", 64'(seen), 64'd1);
    check("clear_hold_rise", 64'(hold_rise_cyc), 64'(s1 + 1));
    check("clear_hold_fall", 64'(hold_fall_cyc), 64'(s1 + NCOEF + 1));
    check("clear_first_wr", 64'(first_clr_cyc), 64'(s1 + 1));
    check("clear_last_wr", 64'(last_clr_cyc), 64'(s1 + NCOEF));
    check("clear_gaps", 64'(clr_gap_bad), 64'd0);
    check("clear_all_written", 64'(wr_q.size()), 64'd0);
    rd_reg(12'h005, 32'h0, 2);
    rd_reg(12'h0ff, 32'h0, 2);

    // Reset in the middle of a clear.
    for (int i = 0; i < NCOEF; i++) wr_q.push_back('{clr: 1'b1, addr: 8'(i), data: 32'h0});
    wr_reg(12'hffd, 32'h1, 1, s, r);
    repeat (20) @(posedge clk_2);
    #1;
    check("mid_clear_hold", 64'(fir_hold), 64'd1);
    rst = 1'b1;
    wr_q.delete();
    #1;
    check_live_reset("rst_clear");
    @(posedge clk_2); #1;
    rst = 1'b0;
    rd_reg(12'hffd, 32'h0, 1);
    wr_q.push_back('{clr: 1'b0, addr: 8'h30, data: 32'hCAFEF00D});
    wr_reg(12'h030, 32'hCAFEF00D, 1, s, r);
    rd_reg(12'h030, 32'hCAFEF00D, 2);

    // Reset in the middle of a hold: pending control word is lost.
    wr_reg(12'hfff, 32'h03010002, 1, s, r);
    repeat (10) @(posedge clk_2);
    #1;
    check("mid_hold_hold", 64'(fir_hold), 64'd1);
    rst = 1'b1;
    #1;
    check_live_reset("rst_hold");
    @(posedge clk_2); #1;
    rst = 1'b0;
    rd_reg(12'hfff, CTRL_RST, 1);
    rd_reg(12'hffd, 32'h0, 1);
    repeat (DRAIN + 4) @(posedge clk_2);
    #1;
    check_live_reset("after_hold_rst");
    wr_q.push_back('{clr: 1'b0, addr: 8'h31, data: 32'h01020304});
    wr_reg(12'h031, 32'h01020304, 1, s, r);

    repeat (3) @(posedge clk_2);
    #1;
    check("rd_queue_drained", 64'(rd_q.size()), 64'd0);
    check("wr_queue_drained", 64'(wr_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
